// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch sequencer: issues PC requests to imem, queues in-order responses, presents them to IF/ID.
// Latency: request accepted at T, response at T+1 or later, instruction visible on if_* one cycle after the response.
// Backpressure: requests are credit-limited to DEPTH (outstanding + queued); id_stall holds the queue head.
module if_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        id_stall,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic        flushing
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {BOOT, RUN, FLUSH} state_t;

  state_t        state, state_n;
  logic [31:0]   pc, pc_n;
  logic [CW-1:0] outstanding, out_n;
  logic [CW-1:0] count, count_n;
  logic [PW-1:0] head, tail;
  logic [31:0]   q_pc    [DEPTH];
  logic [31:0]   q_instr [DEPTH];
  logic [31:0]   last_pc, last_instr;
  logic [31:0]   redir_tgt, rsp_pc;
  logic          rsp_ok, accept, push, pop, credit;

  assign redir_tgt = {redirect_pc[31:2], 2'b00};

  // Responses with nothing outstanding are protocol errors and are ignored.
  assign rsp_ok = imem_rsp_valid && (outstanding != '0);

  // Credit covers both in-flight requests and queued entries, so a response always has a slot.
  assign credit         = ({1'b0, outstanding} + {1'b0, count}) < (CW+1)'(DEPTH);
  assign imem_req_valid = (state == RUN) && !redirect_valid && credit;
  assign imem_req_addr  = pc;
  assign accept         = imem_req_valid && imem_req_ready;

  // Requests since the last redirect are sequential, so the oldest in-flight PC is pc - 4*outstanding.
  assign rsp_pc = pc - {{(30-CW){1'b0}}, outstanding, 2'b00};

  assign push  = rsp_ok && (state == RUN) && !redirect_valid;
  assign pop   = if_valid && !id_stall && !redirect_valid;
  assign out_n = outstanding - CW'(rsp_ok) + CW'(accept);

  assign if_valid = (count != '0);
  assign if_pc    = if_valid ? q_pc[head]    : last_pc;
  assign if_instr = if_valid ? q_instr[head] : last_instr;
  assign flushing = (state == FLUSH);

  // Next-state and next-PC: redirects always capture the target; FLUSH drains until nothing is in flight.
  always_comb begin
    state_n = state;
    pc_n    = pc;
    case (state)
      BOOT: begin
        state_n = RUN;
        if (redirect_valid) pc_n = redir_tgt;
      end
      RUN: begin
        if (redirect_valid) begin
          pc_n    = redir_tgt;
          state_n = (out_n != '0) ? FLUSH : RUN;
        end else if (accept) begin
          pc_n = pc + 32'd4;
        end
      end
      FLUSH: begin
        if (redirect_valid) pc_n = redir_tgt;
        if (out_n == '0) state_n = RUN;
      end
      default: state_n = BOOT;
    endcase
  end

  // Queue occupancy: a redirect empties the queue and voids any same-cycle pop.
  always_comb begin
    count_n = count;
    if (redirect_valid) count_n = '0;
    else                count_n = count + CW'(push) - CW'(pop);
  end

  // Control state, pointers and the held copy of the last presented instruction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= BOOT;
      pc          <= RESET_PC;
      outstanding <= '0;
      count       <= '0;
      head        <= '0;
      tail        <= '0;
      last_pc     <= '0;
      last_instr  <= '0;
    end else begin
      state       <= state_n;
      pc          <= pc_n;
      outstanding <= out_n;
      count       <= count_n;
      if (if_valid) begin
        last_pc    <= q_pc[head];
        last_instr <= q_instr[head];
      end
      if (redirect_valid) begin
        head <= '0;
        tail <= '0;
      end else begin
        if (pop)  head <= head + 1'b1;
        if (push) tail <= tail + 1'b1;
      end
    end
  end

  // Queue storage, written at the tail with the response word and its PC.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        q_pc[i]    <= '0;
        q_instr[i] <= '0;
      end
    end else if (push) begin
      q_pc[tail]    <= rsp_pc;
      q_instr[tail] <= imem_rsp_data;
    end
  end

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Bench for if_fetch_ctrl: directed scenarios pinned with literal values, then randomized traffic.
// A queue-based model of fetch behaviour and a latency-randomized memory drive the comparisons.
// All DUT sampling happens on the falling edge or 1 time unit after it.
module tb_if_fetch_ctrl;

  localparam int          DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_stall;
  logic        if_valid;
  logic [31:0] if_pc, if_instr;
  logic        flushing;

  always #5 clk = ~clk;

  if_fetch_ctrl #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .id_stall(id_stall),
    .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr), .flushing(flushing)
  );

  typedef struct {logic [31:0] pc; logic [31:0] instr;} ent_t;
  typedef struct {logic [31:0] addr; logic [31:0] data; int due;} mreq_t;

  // Reference model state
  ent_t        m_q[$];
  mreq_t       mem_q[$];
  bit          m_boot, m_flush;
  int          m_out;
  logic [31:0] m_pc, m_last_pc, m_last_instr;

  int n_chk = 0, n_pass = 0, cyc = 0;

  // Directed stimulus controls
  bit          rand_mode = 0;
  bit          d_ready = 0, d_redirect = 0, d_stall = 0, d_hold = 0;
  logic [31:0] d_target = 32'h0;

  // Last sampled values, for literal checks by the directed scenarios
  bit          obs_req_valid, obs_if_valid, obs_flushing, obs_rsp;
  logic [31:0] obs_addr;
  logic [31:0] acc_log[$];
  int          first_vld;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic model_reset();
    m_q.delete();
    mem_q.delete();
    acc_log.delete();
    m_boot       = 1;
    m_flush      = 0;
    m_out        = 0;
    m_pc         = RESET_PC;
    m_last_pc    = 32'h0;
    m_last_instr = 32'h0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst            = 1'b1;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    redirect_valid = 1'b0;
    id_stall       = 1'b0;
    model_reset();
    #1;
    chk("rst_req_valid", imem_req_valid, 32'h0);
    chk("rst_req_addr",  imem_req_addr,  32'h0000_0000);
    chk("rst_if_valid",  if_valid,       32'h0);
    chk("rst_if_pc",     if_pc,          32'h0);
    chk("rst_if_instr",  if_instr,       32'h0);
    chk("rst_flushing",  flushing,       32'h0);
    @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  // One clock cycle: check registered outputs, drive inputs, check request outputs, advance the model.
  task automatic step();
    bit    exp_rv, acc, rsp_ok;
    int    out_n;
    mreq_t r;
    @(negedge clk);
    chk("if_valid", if_valid, m_q.size() > 0);
    chk("if_pc",    if_pc,    (m_q.size() > 0) ? m_q[0].pc    : m_last_pc);
    chk("if_instr", if_instr, (m_q.size() > 0) ? m_q[0].instr : m_last_instr);
    chk("flushing", flushing, m_flush);
    obs_if_valid = if_valid;
    obs_flushing = flushing;
    if (rand_mode) begin
      imem_req_ready = ($urandom_range(0, 3) != 0);
      id_stall       = ($urandom_range(0, 2) == 0);
      redirect_valid = ($urandom_range(0, 11) == 0);
      redirect_pc    = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      if (mem_q.size() > 0 && mem_q[0].due <= cyc) imem_rsp_valid = ($urandom_range(0, 3) != 0);
      else imem_rsp_valid = (mem_q.size() == 0) && ($urandom_range(0, 19) == 0);
    end else begin
      imem_req_ready = d_ready;
      id_stall       = d_stall;
      redirect_valid = d_redirect;
      redirect_pc    = d_target;
      imem_rsp_valid = !d_hold && mem_q.size() > 0 && mem_q[0].due <= cyc;
    end
    imem_rsp_data = (imem_rsp_valid && mem_q.size() > 0) ? mem_q[0].data : $urandom;
    obs_rsp = imem_rsp_valid;
    #1;
    exp_rv = !m_boot && !m_flush && !redirect_valid && (m_out + m_q.size() < DEPTH);
    chk("req_valid", imem_req_valid, exp_rv);
    if (exp_rv) chk("req_addr", imem_req_addr, m_pc);
    obs_req_valid = imem_req_valid;
    obs_addr      = imem_req_addr;
    acc    = exp_rv && imem_req_ready;
    rsp_ok = imem_rsp_valid && (m_out > 0);
    out_n  = m_out - int'(rsp_ok) + int'(acc);
    @(posedge clk);
    if (imem_rsp_valid && mem_q.size() > 0) r = mem_q.pop_front();
    if (acc) begin
      mem_q.push_back('{m_pc, $urandom, cyc + (rand_mode ? int'($urandom_range(1, 4)) : 1)});
      acc_log.push_back(m_pc);
    end
    if (m_q.size() > 0) begin
      m_last_pc    = m_q[0].pc;
      m_last_instr = m_q[0].instr;
    end
    if (redirect_valid) begin
      m_q.delete();
      m_pc    = {redirect_pc[31:2], 2'b00};
      m_flush = (out_n > 0);
      m_boot  = 0;
    end else if (m_boot) begin
      m_boot = 0;
    end else if (m_flush) begin
      if (out_n == 0) m_flush = 0;
    end else begin
      if (m_q.size() > 0 && !id_stall) void'(m_q.pop_front());
      if (rsp_ok) m_q.push_back('{r.addr, r.data});
      if (acc) m_pc = m_pc + 32'd4;
    end
    m_out = out_n;
    cyc++;
  endtask

  initial begin
    rst = 1'b1;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
    redirect_valid = 1'b0; redirect_pc = 32'h0; id_stall = 1'b0;
    model_reset();

    // Streaming from reset with a 1-cycle memory
    do_reset();
    d_ready = 1; d_stall = 0; d_hold = 0; d_redirect = 0;
    first_vld = 0;
    for (int i = 1; i <= 8; i++) begin
      step();
      if (obs_if_valid && first_vld == 0) first_vld = i;
    end
    chk("t1_first_if_valid_cycle", first_vld, 4);
    chk("t1_three_accepts", acc_log.size() >= 3, 1);
    chk("t1_addr0", acc_log[0], 32'h0000_0000);
    chk("t1_addr1", acc_log[1], 32'h0000_0004);
    chk("t1_addr2", acc_log[2], 32'h0000_0008);

    // Decode stalled: requests stop at the credit limit
    do_reset();
    d_stall = 1;
    repeat (12) step();
    chk("t2_accepts_under_stall", acc_log.size(), 2);
    chk("t2_req_valid_low", obs_req_valid, 0);
    d_stall = 0;
    repeat (6) step();

    // Redirect with two requests in flight
    do_reset();
    d_hold = 1;
    repeat (4) step();
    chk("t3_two_outstanding", acc_log.size(), 2);
    d_redirect = 1; d_target = 32'h0000_0100;
    step();
    d_redirect = 0; d_hold = 0;
    step();
    chk("t3_flushing", obs_flushing, 1);
    step();
    chk("t3_still_flushing", obs_flushing, 1);
    step();
    chk("t3_flush_done", obs_flushing, 0);
    chk("t3_req_valid", obs_req_valid, 1);
    chk("t3_req_addr", obs_addr, 32'h0000_0100);

    // Redirect with an empty pipe, unaligned target
    d_ready = 0;
    repeat (3) step();
    d_ready = 1; d_redirect = 1; d_target = 32'h0000_0203;
    step();
    d_redirect = 0;
    step();
    chk("t4_no_flush", obs_flushing, 0);
    chk("t4_req_valid", obs_req_valid, 1);
    chk("t4_req_addr", obs_addr, 32'h0000_0200);

    // Redirect coincident with a response and a consume
    do_reset();
    repeat (3) step();
    d_redirect = 1; d_target = 32'h0000_0040;
    step();
    chk("t5_pre_if_valid", obs_if_valid, 1);
    chk("t5_pre_rsp", obs_rsp, 1);
    d_redirect = 0;
    step();
    chk("t5_if_valid_dropped", obs_if_valid, 0);
    chk("t5_req_addr", obs_addr, 32'h0000_0040);

    // PC wrap at the top of the address space
    d_redirect = 1; d_target = 32'hFFFF_FFFE;
    step();
    d_redirect = 0;
    step();
    chk("t6_req_top", obs_addr, 32'hFFFF_FFFC);
    step();
    chk("t6_req_wrap_valid", obs_req_valid, 1);
    chk("t6_req_wrap", obs_addr, 32'h0000_0000);

    // Reset while flushing
    d_hold = 1;
    repeat (2) step();
    d_redirect = 1; d_target = 32'h0000_0300;
    step();
    d_redirect = 0;
    step();
    chk("t6_mid_flush", obs_flushing, 1);
    do_reset();
    d_hold = 0;
    step();
    chk("t6_boot_no_req", obs_req_valid, 0);
    step();
    chk("t6_post_reset_req_valid", obs_req_valid, 1);
    chk("t6_post_reset_addr", obs_addr, 32'h0000_0000);

    // Randomized traffic with occasional resets
    rand_mode = 1;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 499) == 0) do_reset();
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
